merge_sort_ctrl: RTL and testbench



---
 rtl/merge_sort_ctrl_if.sv | 25 ++
 rtl/merge_sort_ctrl.sv | 131 +++++++++++++
 tb/tb_merge_sort_ctrl.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/merge_sort_ctrl_if.sv
// Stream bundle for merge_sort_ctrl: byte input stream, sorted output stream and status.
// The master modport is the side that feeds and drains the controller.
interface merge_sort_ctrl_if #(
  parameter int W = 8
);
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;
  logic         out_last;
  logic         busy;
  logic         done;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_last, busy, done
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_last, busy, done
  );
endinterface

// File: rtl/merge_sort_ctrl.sv
// Bottom-up merge sort sequencer: loads N bytes into bank A, runs log2(N) ping-pong
// merge passes at one element per cycle, then streams the ascending block out.
module merge_sort_ctrl #(
  parameter int N = 8,
  parameter int W = 8
) (
  input logic            clk,
  input logic            rst,
  merge_sort_ctrl_if.slave bus
);
  localparam int AW = $clog2(N);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] ONE  = CW'(1);
  localparam logic [CW-1:0] LAST = CW'(N - 1);
  localparam logic [CW-1:0] FULL = CW'(N);

  localparam logic [1:0] S_LOAD  = 2'd0;
  localparam logic [1:0] S_MERGE = 2'd1;
  localparam logic [1:0] S_OUT   = 2'd2;

  logic [1:0]    state;
  logic [CW-1:0] wr_cnt, rd_cnt, k, i, j, w;
  logic          src_sel;  // 0: src = A, dst = B
  logic          done_q;

  logic [W-1:0] bank_a [N];
  logic [W-1:0] bank_b [N];

  logic [CW-1:0] w2, base, lim_l, lim_r, k_nxt;
  logic [W-1:0]  src_i, src_j, merge_val, rd_val;
  logic          take_left, pass_end, run_end;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    take_left = 1'b0;
    w2        = w << 1;
    base      = k & ~(w2 - ONE);
    lim_l     = base + w;
    lim_r     = base + w2;
    k_nxt     = k + ONE;
    pass_end  = (k == LAST);
    run_end   = ((k_nxt & (w2 - ONE)) == '0);
    src_i     = src_sel ? bank_b[i[AW-1:0]] : bank_a[i[AW-1:0]];
    src_j     = src_sel ? bank_b[j[AW-1:0]] : bank_a[j[AW-1:0]];
    rd_val    = src_sel ? bank_b[rd_cnt[AW-1:0]] : bank_a[rd_cnt[AW-1:0]];
    if (i == lim_l)      take_left = 1'b0;
    else if (j == lim_r) take_left = 1'b1;
    else                 take_left = (src_i <= src_j);  // ties go left: stable
    merge_val = take_left ? src_i : src_j;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= S_LOAD;
      wr_cnt  <= '0;
      rd_cnt  <= '0;
      k       <= '0;
      i       <= '0;
      j       <= '0;
      w       <= ONE;
      src_sel <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        S_LOAD: begin
          if (bus.in_valid) begin
            wr_cnt <= wr_cnt + ONE;
            if (wr_cnt == LAST) begin
              state   <= S_MERGE;
              w       <= ONE;
              src_sel <= 1'b0;
              k       <= '0;
              i       <= '0;
              j       <= ONE;
            end
          end
        end
        S_MERGE: begin
          k <= k_nxt;
          if (take_left) i <= i + ONE;
          else           j <= j + ONE;
          if (pass_end) begin
            src_sel <= ~src_sel;
            w       <= w2;
            k       <= '0;
            i       <= '0;
            j       <= w2;
            if (w2 == FULL) begin
              state  <= S_OUT;
              done_q <= 1'b1;
            end
          end else if (run_end) begin
            i <= k_nxt;
            j <= k_nxt + w;
          end
        end
        S_OUT: begin
          if (bus.out_ready) begin
            rd_cnt <= rd_cnt + ONE;
            if (rd_cnt == LAST) begin
              state  <= S_LOAD;
              wr_cnt <= '0;
              rd_cnt <= '0;
            end
          end
        end
        default: state <= S_LOAD;
      endcase
    end
  end

  // NOTE: the banks carry no reset; stale contents are never observable because
  // out_data is forced to zero outside OUT.
  always_ff @(posedge clk) begin
    if (state == S_LOAD && bus.in_valid) begin
      bank_a[wr_cnt[AW-1:0]] <= bus.in_data;
    end else if (state == S_MERGE) begin
      if (src_sel) bank_a[k[AW-1:0]] <= merge_val;
      else         bank_b[k[AW-1:0]] <= merge_val;
    end
  end

  assign bus.in_ready  = (state == S_LOAD);
  assign bus.out_valid = (state == S_OUT);
  assign bus.out_data  = (state == S_OUT) ? rd_val : '0;
  assign bus.out_last  = (state == S_OUT) && (rd_cnt == LAST);
  assign bus.busy      = (state == S_MERGE) || (state == S_OUT);
  assign bus.done      = done_q;
endmodule

// File: tb/tb_merge_sort_ctrl.sv
// Directed bench for merge_sort_ctrl: table of N=8 blocks with expected sorted output,
// plus hand sequences for reset mid-merge and an N=2 instance.
module tb_merge_sort_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  merge_sort_ctrl_if #(.W(8)) if8 ();
  merge_sort_ctrl_if #(.W(8)) if2 ();

  merge_sort_ctrl #(.N(8), .W(8)) dut8 (.clk(clk), .rst(rst), .bus(if8));
  merge_sort_ctrl #(.N(2), .W(8)) dut2 (.clk(clk), .rst(rst), .bus(if2));

  typedef struct packed {
    logic [63:0] din;   // byte b of the block in bits [8b+7:8b]
    logic [63:0] exp;
    logic        bp;    // random out_ready
    logic        junk;  // in_valid held high with junk during MERGE/OUT
  } vec_t;

  vec_t vecs [4];
  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] pack8(input logic [7:0] b0, b1, b2, b3, b4, b5, b6, b7);
    return {b7, b6, b5, b4, b3, b2, b1, b0};
  endfunction

  task automatic load8(input logic [63:0] din);
    for (int b = 0; b < 8; b++) begin
      @(negedge clk);
      if8.in_valid = 1'b1;
      if8.in_data  = din[b*8 +: 8];
      check("load_in_ready", 32'(if8.in_ready), 32'd1);
      @(posedge clk);
    end
  endtask

  task automatic run_block(input vec_t v);
    int n;
    int got;
    int guard;
    int dcnt;
    load8(v.din);
    @(negedge clk);
    if (v.junk) if8.in_data = 8'($urandom);
    else        if8.in_valid = 1'b0;
    check("in_ready_drop", 32'(if8.in_ready), 32'd0);
    check("busy_merge", 32'(if8.busy), 32'd1);
    n = 0;
    while (!if8.out_valid && n < 100) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if (v.junk) if8.in_data = 8'($urandom);
    end
    check("merge_cycles", 32'(n), 32'd24);
    got = 0; guard = 0; dcnt = 0;
    while (got < 8 && guard < 200) begin
      if (v.junk) if8.in_data = 8'($urandom);
      if8.out_ready = v.bp ? 1'($urandom_range(0, 1)) : 1'b1;
      if (if8.done) dcnt++;
      check("out_valid", 32'(if8.out_valid), 32'd1);
      check("out_data", 32'(if8.out_data), 32'(v.exp[got*8 +: 8]));
      check("out_last", 32'(if8.out_last), 32'(got == 7));
      check("in_ready_out", 32'(if8.in_ready), 32'd0);
      @(posedge clk);
      if (if8.out_ready) got++;
      guard++;
      @(negedge clk);
    end
    if8.in_valid  = 1'b0;
    if8.out_ready = 1'b0;
    check("beats", 32'(got), 32'd8);
    check("done_pulses", 32'(dcnt), 32'd1);
    check("idle_in_ready", 32'(if8.in_ready), 32'd1);
    check("idle_out_valid", 32'(if8.out_valid), 32'd0);
    check("idle_out_data", 32'(if8.out_data), 32'd0);
    check("idle_busy", 32'(if8.busy), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    vec_t rv;

    vecs[0] = '{din: pack8(8'h08, 8'h03, 8'h05, 8'h01, 8'h07, 8'h02, 8'h06, 8'h04),
                exp: pack8(8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08),
                bp: 1'b0, junk: 1'b0};
    vecs[1] = '{din: pack8(8'hFF, 8'hFE, 8'hFD, 8'hFC, 8'hFB, 8'hFA, 8'hF9, 8'hF8),
                exp: pack8(8'hF8, 8'hF9, 8'hFA, 8'hFB, 8'hFC, 8'hFD, 8'hFE, 8'hFF),
                bp: 1'b0, junk: 1'b0};
    vecs[2] = '{din: pack8(8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07),
                exp: pack8(8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07),
                bp: 1'b1, junk: 1'b0};
    vecs[3] = '{din: pack8(8'h05, 8'h05, 8'h00, 8'h05, 8'h00, 8'hFF, 8'h00, 8'h05),
                exp: pack8(8'h00, 8'h00, 8'h00, 8'h05, 8'h05, 8'h05, 8'h05, 8'hFF),
                bp: 1'b1, junk: 1'b1};

    if8.in_valid = 1'b0; if8.in_data = '0; if8.out_ready = 1'b0;
    if2.in_valid = 1'b0; if2.in_data = '0; if2.out_ready = 1'b0;

    #1;
    check("rst_in_ready", 32'(if8.in_ready), 32'd1);
    check("rst_out_valid", 32'(if8.out_valid), 32'd0);
    check("rst_out_data", 32'(if8.out_data), 32'd0);
    check("rst_out_last", 32'(if8.out_last), 32'd0);
    check("rst_busy", 32'(if8.busy), 32'd0);
    check("rst_done", 32'(if8.done), 32'd0);
    @(negedge clk);
    rst = 1'b1;

    for (int t = 0; t < 4; t++) run_block(vecs[t]);

    // Reset in the middle of MERGE discards the partial work.
    load8(vecs[0].din);
    repeat (10) @(posedge clk);
    @(negedge clk);
    if8.in_valid = 1'b0;
    check("pre_rst_busy", 32'(if8.busy), 32'd1);
    rst = 1'b0;
    #1;
    check("mid_rst_in_ready", 32'(if8.in_ready), 32'd1);
    check("mid_rst_out_valid", 32'(if8.out_valid), 32'd0);
    check("mid_rst_out_data", 32'(if8.out_data), 32'd0);
    check("mid_rst_busy", 32'(if8.busy), 32'd0);
    check("mid_rst_done", 32'(if8.done), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    rv = '{din: pack8(8'h40, 8'h10, 8'h70, 8'h20, 8'h60, 8'h30, 8'h80, 8'h50),
           exp: pack8(8'h10, 8'h20, 8'h30, 8'h40, 8'h50, 8'h60, 8'h70, 8'h80),
           bp: 1'b0, junk: 1'b0};
    run_block(rv);

    // N=2 instance: two-cycle merge, junk ignored outside LOAD.
    @(negedge clk);
    if2.in_valid = 1'b1; if2.in_data = 8'h09;
    @(posedge clk);
    @(negedge clk);
    if2.in_data = 8'h04;
    @(posedge clk);
    @(negedge clk);
    if2.in_data = 8'hA5;
    check("n2_in_ready_drop", 32'(if2.in_ready), 32'd0);
    n = 0;
    while (!if2.out_valid && n < 50) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if2.in_data = 8'($urandom);
    end
    check("n2_merge_cycles", 32'(n), 32'd2);
    check("n2_done", 32'(if2.done), 32'd1);
    if2.out_ready = 1'b1;
    check("n2_data0", 32'(if2.out_data), 32'h04);
    check("n2_last0", 32'(if2.out_last), 32'd0);
    @(posedge clk);
    @(negedge clk);
    check("n2_data1", 32'(if2.out_data), 32'h09);
    check("n2_last1", 32'(if2.out_last), 32'd1);
    check("n2_done_pulse", 32'(if2.done), 32'd0);
    @(posedge clk);
    @(negedge clk);
    if2.in_valid = 1'b0;
    if2.out_ready = 1'b0;
    check("n2_idle_in_ready", 32'(if2.in_ready), 32'd1);
    check("n2_idle_out_valid", 32'(if2.out_valid), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
